// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator: oversampled rx_tick, per-bit tx_tick and a bit-rate square wave.
// The tick period is int clocks, plus one whenever the fractional accumulator carries.
module baud_gen_frac #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [2:0]        baud_sel,
    input  logic [DIV_W-1:0]  custom_div,
    input  logic [FRAC_W-1:0] custom_frac,
    output logic              rx_tick,
    output logic              tx_tick,
    output logic              baud_clk,
    output logic              cfg_err
);

    localparam int D_W  = DIV_W + FRAC_W;
    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

    function automatic logic [D_W-1:0] preset_div(input int sel);
        longint baud;
        longint num;
        longint den;
        case (sel)
            0:       baud = 2400;
            1:       baud = 4800;
            2:       baud = 9600;
            3:       baud = 19200;
            4:       baud = 38400;
            5:       baud = 57600;
            6:       baud = 115200;
            default: baud = 0;
        endcase
        num = longint'(CLK_HZ) << FRAC_W;
        den = baud * longint'(OVERSAMPLE);
        if (baud == 0)
            preset_div = '0;
        else
            preset_div = D_W'((num + den / 2) / den);
    endfunction

    localparam logic [D_W-1:0] PRESET [8] = '{
        preset_div(0), preset_div(1), preset_div(2), preset_div(3),
        preset_div(4), preset_div(5), preset_div(6), preset_div(7)
    };

    logic [2:0]        sel_sh;
    logic [DIV_W-1:0]  div_sh;
    logic [FRAC_W-1:0] frac_sh;
    logic              en_sh;

    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic              carry;
    logic [OS_W-1:0]   os_cnt;

    logic [DIV_W-1:0]  int_eff;
    logic [FRAC_W-1:0] frac_eff;
    logic [DIV_W-1:0]  tc_val;
    logic [FRAC_W:0]   acc_sum;
    logic              restart;
    logic              err_c;
    logic              running;
    logic              tc;

    // The error flag only moves when the shadows move, and a shadow move is
    // itself a restart, so clearing an error always restarts the sequence.
    always_comb begin
        int_eff  = PRESET[sel_sh][D_W-1:FRAC_W];
        frac_eff = PRESET[sel_sh][FRAC_W-1:0];
        if (sel_sh == 3'd7) begin
            int_eff  = div_sh;
            frac_eff = frac_sh;
        end
        restart = (enable && !en_sh)
                || (baud_sel != sel_sh)
                || ((baud_sel == 3'd7) && ((custom_div != div_sh) || (custom_frac != frac_sh)));
        err_c   = int_eff < DIV_W'(2);
        running = enable && !err_c;
        tc_val  = int_eff - DIV_W'(1) + {{(DIV_W-1){1'b0}}, carry};
        tc      = (cnt == tc_val);
        acc_sum = {1'b0, acc} + {1'b0, frac_eff};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel_sh   <= '0;
            div_sh   <= '0;
            frac_sh  <= '0;
            en_sh    <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            os_cnt   <= '0;
            rx_tick  <= 1'b0;
            tx_tick  <= 1'b0;
            baud_clk <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            sel_sh  <= baud_sel;
            div_sh  <= custom_div;
            frac_sh <= custom_frac;
            en_sh   <= enable;
            cfg_err <= err_c;
            if (restart || !running) begin
                cnt      <= '0;
                acc      <= '0;
                carry    <= 1'b0;
                os_cnt   <= '0;
                rx_tick  <= 1'b0;
                tx_tick  <= 1'b0;
                baud_clk <= 1'b0;
            end else if (tc) begin
                cnt     <= '0;
                acc     <= acc_sum[FRAC_W-1:0];
                carry   <= acc_sum[FRAC_W];
                rx_tick <= 1'b1;
                tx_tick <= (os_cnt == OS_LAST);
                os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
                if (os_cnt == OS_HALF || os_cnt == OS_LAST)
                    baud_clk <= ~baud_clk;
            end else begin
                cnt     <= cnt + DIV_W'(1);
                rx_tick <= 1'b0;
                tx_tick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: a default instance (OVERSAMPLE=16) and an OVERSAMPLE=4 instance,
// checked cycle by cycle against closed-form tick times.
module tb_baud_gen_frac;

    localparam int CLK_HZ = 50_000_000;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic        en_a, en_b;
    logic [2:0]  sel_a, sel_b;
    logic [15:0] div_a, div_b;
    logic [3:0]  frac_a, frac_b;
    logic        rx_a, tx_a, bc_a, err_a;
    logic        rx_b, tx_b, bc_b, err_b;

    baud_gen_frac dut_a (
        .clock(clock), .reset_n(reset_n), .enable(en_a), .baud_sel(sel_a),
        .custom_div(div_a), .custom_frac(frac_a),
        .rx_tick(rx_a), .tx_tick(tx_a), .baud_clk(bc_a), .cfg_err(err_a)
    );

    baud_gen_frac #(.OVERSAMPLE(4)) dut_b (
        .clock(clock), .reset_n(reset_n), .enable(en_b), .baud_sel(sel_b),
        .custom_div(div_b), .custom_frac(frac_b),
        .rx_tick(rx_b), .tx_tick(tx_b), .baud_clk(bc_b), .cfg_err(err_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int w_bad, w_first, w_t33, w_ntx, w_tx_first, w_tx_last;

    // k-th rx_tick after a restart lands k*int + floor((k-1)*frac/16) clocks later.
    function automatic longint tick_time(input int intv, input int frac, input int k);
        return longint'(k) * intv + (longint'(k - 1) * frac) / 16;
    endfunction

    function automatic real baud_of(input int sel);
        case (sel)
            0:       return 2400.0;
            1:       return 4800.0;
            2:       return 9600.0;
            3:       return 19200.0;
            4:       return 38400.0;
            5:       return 57600.0;
            default: return 115200.0;
        endcase
    endfunction

    function automatic int preset_d(input int sel, input int os);
        return $rtoi(real'(CLK_HZ) * 16.0 / (baud_of(sel) * real'(os)) + 0.5);
    endfunction

    // Caller sets inputs at a negedge; the following posedge is the restart edge (n=0 sample).
    task automatic run_window(input bit use_b, input int intv, input int frac, input int ncyc);
        int     k, ticks, os, n_rx;
        longint nt;
        bit     er, et, eb;
        logic   orx, otx, obc, oer;
        os = use_b ? 4 : 16;
        k = 1; ticks = 0; n_rx = 0;
        nt = tick_time(intv, frac, 1);
        w_bad = 0; w_first = -1; w_t33 = -1; w_ntx = 0; w_tx_first = -1; w_tx_last = -1;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clock);
            orx = use_b ? rx_b  : rx_a;
            otx = use_b ? tx_b  : tx_a;
            obc = use_b ? bc_b  : bc_a;
            oer = use_b ? err_b : err_a;
            er = (longint'(n) == nt);
            if (er) begin
                ticks = k;
                k++;
                nt = tick_time(intv, frac, k);
            end
            et = er && (ticks % os == 0);
            eb = (ticks % os) >= os / 2;
            if (orx === 1'b1) begin
                n_rx++;
                if (n_rx == 33) w_t33 = n;
            end
            if (otx === 1'b1) begin
                w_ntx++;
                if (w_tx_first < 0) w_tx_first = n;
                w_tx_last = n;
            end
            if ({orx, otx, obc} !== {er, et, eb} || (n > 0 && oer !== 1'b0)) begin
                w_bad++;
                if (w_first < 0) w_first = n;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        en_a = 0; sel_a = 0; div_a = 0; frac_a = 0;
        en_b = 0; sel_b = 0; div_b = 0; frac_b = 0;
        repeat (3) @(negedge clock);
        n_tests++;
        if ({rx_a, tx_a, bc_a, err_a, rx_b, tx_b, bc_b, err_b} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs %b, want 00000000",
                     {rx_a, tx_a, bc_a, err_a, rx_b, tx_b, bc_b, err_b});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        n_tests++;
        if ({rx_a, tx_a, bc_a, err_a, rx_b, tx_b, bc_b, err_b} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: outputs %b, want 00000000",
                     {rx_a, tx_a, bc_a, err_a, rx_b, tx_b, bc_b, err_b});
        end
    endtask

    task automatic test_preset_avg(input int sel, input int ntx_need);
        int   d, i, f, ncyc;
        real  avg, want;
        d = preset_d(sel, 16); i = d / 16; f = d % 16;
        ncyc = int'(tick_time(i, f, 16 * ntx_need)) + 5;
        @(negedge clock);
        sel_a = 3'(sel); en_a = 1'b1;
        run_window(0, i, f, ncyc);
        n_tests++;
        if (w_bad !== 0) begin
            n_fail++;
            $display("FAIL preset_sel%0d_wave: %0d bad cycles (first at %0d), want 0", sel, w_bad, w_first);
        end
        want = real'(CLK_HZ) / baud_of(sel);
        avg = (w_ntx > 1) ? real'(w_tx_last - w_tx_first) / real'(w_ntx - 1) : 0.0;
        n_tests++;
        if (w_ntx < ntx_need || avg < want - 1.0 || avg > want + 1.0) begin
            n_fail++;
            $display("FAIL preset_sel%0d_avg: %0d tx ticks avg %f clocks, want >=%0d ticks avg %f +-1",
                     sel, w_ntx, avg, ntx_need, want);
        end
    endtask

    task automatic test_switch();
        int d2, d6;
        d2 = preset_d(2, 16); d6 = preset_d(6, 16);
        @(negedge clock);
        sel_a = 3'd2; en_a = 1'b1;
        // Stop one cycle short of the 12th tick so the switch lands on a due tick with baud_clk high.
        run_window(0, d2 / 16, d2 % 16, int'(tick_time(d2 / 16, d2 % 16, 12)));
        n_tests++;
        if (w_bad !== 0) begin
            n_fail++;
            $display("FAIL switch_pre: %0d bad cycles (first at %0d), want 0", w_bad, w_first);
        end
        sel_a = 3'd6;
        run_window(0, d6 / 16, d6 % 16, 150);
        n_tests++;
        if (w_bad !== 0) begin
            n_fail++;
            $display("FAIL switch_post: %0d bad cycles (first at %0d), want 0", w_bad, w_first);
        end
    endtask

    task automatic test_random_presets();
        for (int r = 0; r < 4; r++) begin
            int s, d;
            s = $urandom_range(3, 6);
            d = preset_d(s, 16);
            @(negedge clock); en_a = 1'b0;
            @(negedge clock); en_a = 1'b1; sel_a = 3'(s);
            run_window(0, d / 16, d % 16, int'(tick_time(d / 16, d % 16, 4)) + 3);
            n_tests++;
            if (w_bad !== 0) begin
                n_fail++;
                $display("FAIL rand_preset_sel%0d: %0d bad cycles (first at %0d), want 0", s, w_bad, w_first);
            end
        end
    endtask

    task automatic test_custom_basic();
        @(negedge clock);
        sel_b = 3'd7; div_b = 16'd4; frac_b = 4'd0; en_b = 1'b1;
        run_window(1, 4, 0, 48);
        n_tests++;
        if (w_bad !== 0 || w_ntx !== 2) begin
            n_fail++;
            $display("FAIL custom_div4: %0d bad cycles (first at %0d), %0d tx ticks; want 0 bad, 2 tx",
                     w_bad, w_first, w_ntx);
        end
    endtask

    task automatic test_frac();
        @(negedge clock);
        frac_b = 4'd8;
        run_window(1, 4, 8, 160);
        n_tests++;
        if (w_bad !== 0) begin
            n_fail++;
            $display("FAIL frac_wave: %0d bad cycles (first at %0d), want 0", w_bad, w_first);
        end
        n_tests++;
        if (longint'(w_t33) !== tick_time(4, 8, 33)) begin
            n_fail++;
            $display("FAIL frac_t33: 33rd tick at %0d, want %0d", w_t33, tick_time(4, 8, 33));
        end
    endtask

    task automatic test_random_custom();
        for (int r = 0; r < 6; r++) begin
            int dv, fr;
            dv = $urandom_range(2, 9);
            fr = $urandom_range(0, 15);
            @(negedge clock); en_b = 1'b0;
            @(negedge clock); en_b = 1'b1; sel_b = 3'd7; div_b = 16'(dv); frac_b = 4'(fr);
            run_window(1, dv, fr, int'(tick_time(dv, fr, 10)) + 3);
            n_tests++;
            if (w_bad !== 0) begin
                n_fail++;
                $display("FAIL rand_custom_%0d_%0d: %0d bad cycles (first at %0d), want 0",
                         dv, fr, w_bad, w_first);
            end
        end
    endtask

    task automatic test_cfg_err();
        int tick_bad, err_bad;
        tick_bad = 0; err_bad = 0;
        @(negedge clock);
        div_b = 16'd1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clock);
            if ({rx_b, tx_b, bc_b} !== 3'b000) tick_bad++;
            if (err_b !== ((n >= 1) ? 1'b1 : 1'b0)) err_bad++;
        end
        n_tests++;
        if (tick_bad !== 0) begin
            n_fail++;
            $display("FAIL cfg_err_quiet: %0d cycles with activity, want 0", tick_bad);
        end
        n_tests++;
        if (err_bad !== 0) begin
            n_fail++;
            $display("FAIL cfg_err_flag: %0d cycles with wrong cfg_err, want 0", err_bad);
        end
        div_b = 16'd3; frac_b = 4'd0;
        run_window(1, 3, 0, 40);
        n_tests++;
        if (w_bad !== 0) begin
            n_fail++;
            $display("FAIL cfg_err_clear: %0d bad cycles (first at %0d), want 0", w_bad, w_first);
        end
    endtask

    task automatic test_enable_drop();
        int act;
        act = 0;
        @(negedge clock); en_b = 1'b0;
        @(negedge clock); en_b = 1'b1; sel_b = 3'd7; div_b = 16'd5; frac_b = 4'd0;
        // 35 is the 7th tick time, so enable falls just before a due tick.
        run_window(1, 5, 0, 35);
        n_tests++;
        if (w_bad !== 0) begin
            n_fail++;
            $display("FAIL en_drop_pre: %0d bad cycles (first at %0d), want 0", w_bad, w_first);
        end
        en_b = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if ({rx_b, tx_b, bc_b} !== 3'b000) act++;
        end
        n_tests++;
        if (act !== 0) begin
            n_fail++;
            $display("FAIL en_drop_quiet: %0d cycles with activity, want 0", act);
        end
        en_b = 1'b1;
        run_window(1, 5, 0, 50);
        n_tests++;
        if (w_bad !== 0) begin
            n_fail++;
            $display("FAIL en_rise_restart: %0d bad cycles (first at %0d), want 0", w_bad, w_first);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock); en_b = 1'b0;
        @(negedge clock); en_b = 1'b1; sel_b = 3'd7; div_b = 16'd4; frac_b = 4'd0;
        run_window(1, 4, 0, 13);
        n_tests++;
        if (w_bad !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_pre: %0d bad cycles (first at %0d), want 0", w_bad, w_first);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({rx_b, tx_b, bc_b, err_b} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_async: outputs %b, want 0000", {rx_b, tx_b, bc_b, err_b});
        end
        @(negedge clock);
        reset_n = 1'b1;
        run_window(1, 4, 0, 40);
        n_tests++;
        if (w_bad !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_restart: %0d bad cycles (first at %0d), want 0", w_bad, w_first);
        end
    endtask

    initial begin
        test_reset();
        test_preset_avg(2, 3);
        test_preset_avg(6, 17);
        test_switch();
        test_random_presets();
        test_custom_basic();
        test_frac();
        test_random_custom();
        test_cfg_err();
        test_enable_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
